// File: rtl/oam_dma_engine.sv
// FF46 OAM DMA engine: copies NUM_BYTES bytes from {page, 8'h00} to DEST_BASE, 4 cycles per byte.
// Optional CPU lock output enabled by defining OAM_DMA_CPU_LOCK_EN.
module oam_dma_engine #(
    parameter int unsigned NUM_BYTES = 160,
    parameter logic [15:0] DEST_BASE = 16'hFE00,
    parameter bit          ECHO_FOLD = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  dma_reg,
    input  logic        dma_write,
    input  logic [7:0]  dma_rdata,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic        dma_OE,
    output logic        dma_WE,
    output logic [7:0]  dma_wdata,
    output logic        dma_done,
    output logic        cpu_block
);

    localparam int unsigned   IdxW    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_BYTES - 1);

    typedef enum logic [2:0] {StIdle, StRd0, StRd1, StWr0, StWr1} state_e;

    state_e          r_state;
    logic [IdxW-1:0] r_idx;
    logic [7:0]      r_src_page;
    logic [7:0]      r_data_latch;
    logic [15:0]     r_addr;
    logic            r_oe;
    logic            r_we;
    logic            r_active;
    logic            r_done;

    logic [7:0]      w_fold_page;
    logic [IdxW-1:0] w_idx_nxt;
    logic [15:0]     w_rd_next_addr;
    logic [15:0]     w_wr_addr;

    // Echo RAM pages E0..FF alias work RAM C0..DF.
    assign w_fold_page    = (ECHO_FOLD && (dma_reg >= 8'hE0)) ? (dma_reg - 8'h20) : dma_reg;
    assign w_idx_nxt      = r_idx + 1'b1;
    assign w_rd_next_addr = {r_src_page, 8'h00} + 16'(w_idx_nxt);
    assign w_wr_addr      = DEST_BASE + 16'(r_idx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= StIdle;
            r_idx        <= '0;
            r_src_page   <= 8'h00;
            r_data_latch <= 8'h00;
            r_addr       <= 16'h0000;
            r_oe         <= 1'b0;
            r_we         <= 1'b0;
            r_active     <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // A new FF46 write restarts from any state, overriding completion.
            if (dma_write) begin
                r_state    <= StRd0;
                r_src_page <= w_fold_page;
                r_idx      <= '0;
                r_addr     <= {w_fold_page, 8'h00};
                r_oe       <= 1'b1;
                r_we       <= 1'b0;
                r_active   <= 1'b1;
            end else begin
                case (r_state)
                    StIdle: r_state <= StIdle;
                    StRd0:  r_state <= StRd1;
                    StRd1: begin
                        r_data_latch <= dma_rdata;
                        r_addr       <= w_wr_addr;
                        r_oe         <= 1'b0;
                        r_we         <= 1'b1;
                        r_state      <= StWr0;
                    end
                    StWr0:  r_state <= StWr1;
                    StWr1: begin
                        r_we <= 1'b0;
                        if (r_idx == LastIdx) begin
                            r_active <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= StIdle;
                        end else begin
                            r_idx   <= w_idx_nxt;
                            r_addr  <= w_rd_next_addr;
                            r_oe    <= 1'b1;
                            r_state <= StRd0;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign dma_active = r_active;
    assign dma_addr   = r_addr;
    assign dma_OE     = r_oe;
    assign dma_WE     = r_we;
    assign dma_wdata  = r_data_latch;
    assign dma_done   = r_done;

`ifdef OAM_DMA_CPU_LOCK_EN
    assign cpu_block = r_active;
`else
    assign cpu_block = 1'b0;
`endif

endmodule

// File: tb/tb_oam_dma_engine.sv
// Bench for oam_dma_engine: two instances (echo fold on/off) against a per-cycle arithmetic
// model of the 4-cycle/byte bus pattern and a golden memory image.
module tb_oam_dma_engine;

    localparam int unsigned N = 160;
`ifdef OAM_DMA_CPU_LOCK_EN
    localparam bit LockEn = 1'b1;
`else
    localparam bit LockEn = 1'b0;
`endif

    logic        clk, rst, dma_write;
    logic [7:0]  dma_reg;
    logic [7:0]  rd_a, rd_b;
    logic        act_a, oe_a, we_a, done_a, blk_a;
    logic        act_b, oe_b, we_b, done_b, blk_b;
    logic [15:0] addr_a, addr_b;
    logic [7:0]  wd_a, wd_b;
    logic        clr_oam;

    logic [7:0]  golden [65536];
    logic [7:0]  oam_a [N];
    logic [7:0]  oam_b [N];

    int n_total = 0;
    int n_bad   = 0;

    oam_dma_engine u_dut_a (
        .clk(clk), .rst(rst), .dma_reg(dma_reg), .dma_write(dma_write), .dma_rdata(rd_a),
        .dma_active(act_a), .dma_addr(addr_a), .dma_OE(oe_a), .dma_WE(we_a),
        .dma_wdata(wd_a), .dma_done(done_a), .cpu_block(blk_a)
    );

    oam_dma_engine #(.ECHO_FOLD(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .dma_reg(dma_reg), .dma_write(dma_write), .dma_rdata(rd_b),
        .dma_active(act_b), .dma_addr(addr_b), .dma_OE(oe_b), .dma_WE(we_b),
        .dma_wdata(wd_b), .dma_done(done_b), .cpu_block(blk_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory unit: registered read, write committed on WE edges into the OAM window.
    always @(posedge clk) begin
        if (oe_a) rd_a <= golden[addr_a];
        if (oe_b) rd_b <= golden[addr_b];
        if (clr_oam) begin
            for (int i = 0; i < N; i++) begin
                oam_a[i] <= 8'h00;
                oam_b[i] <= 8'h00;
            end
        end else begin
            if (we_a && addr_a >= 16'hFE00 && addr_a < 16'hFE00 + 16'(N))
                oam_a[addr_a - 16'hFE00] <= wd_a;
            if (we_b && addr_b >= 16'hFE00 && addr_b < 16'hFE00 + 16'(N))
                oam_b[addr_b - 16'hFE00] <= wd_b;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h want %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [7:0] fold(input logic [7:0] p);
        return (p >= 8'hE0) ? p - 8'h20 : p;
    endfunction

    task automatic check_zero();
        check_eq("rst_act_a", act_a, 0);  check_eq("rst_act_b", act_b, 0);
        check_eq("rst_addr_a", addr_a, 0); check_eq("rst_addr_b", addr_b, 0);
        check_eq("rst_oe_a", oe_a, 0);    check_eq("rst_oe_b", oe_b, 0);
        check_eq("rst_we_a", we_a, 0);    check_eq("rst_we_b", we_b, 0);
        check_eq("rst_wd_a", wd_a, 0);    check_eq("rst_wd_b", wd_b, 0);
        check_eq("rst_done_a", done_a, 0); check_eq("rst_done_b", done_b, 0);
        check_eq("rst_blk_a", blk_a, 0);  check_eq("rst_blk_b", blk_b, 0);
    endtask

    task automatic check_idle(input string tag, input logic exp_done);
        check_eq({tag, "_act_a"}, act_a, 0);  check_eq({tag, "_act_b"}, act_b, 0);
        check_eq({tag, "_oe_a"}, oe_a, 0);    check_eq({tag, "_we_a"}, we_a, 0);
        check_eq({tag, "_oe_b"}, oe_b, 0);    check_eq({tag, "_we_b"}, we_b, 0);
        check_eq({tag, "_done_a"}, done_a, exp_done);
        check_eq({tag, "_done_b"}, done_b, exp_done);
        check_eq({tag, "_blk_a"}, blk_a, 0);  check_eq({tag, "_blk_b"}, blk_b, 0);
    endtask

    // Cycle k (1-based) after a strobe: byte (k-1)/4, phases 0,1 read and 2,3 write.
    task automatic check_cycle(input int k, input logic [7:0] sa, input logic [7:0] sb);
        int b;
        bit rd;
        logic [15:0] ea, eb;
        b  = (k - 1) / 4;
        rd = ((k - 1) % 4) < 2;
        ea = rd ? ({sa, 8'h00} + 16'(b)) : (16'hFE00 + 16'(b));
        eb = rd ? ({sb, 8'h00} + 16'(b)) : (16'hFE00 + 16'(b));
        check_eq("act_a", act_a, 1);   check_eq("act_b", act_b, 1);
        check_eq("oe_a", oe_a, rd);    check_eq("oe_b", oe_b, rd);
        check_eq("we_a", we_a, !rd);   check_eq("we_b", we_b, !rd);
        check_eq("addr_a", addr_a, ea); check_eq("addr_b", addr_b, eb);
        check_eq("done_a", done_a, 0); check_eq("done_b", done_b, 0);
        check_eq("blk_a", blk_a, LockEn); check_eq("blk_b", blk_b, LockEn);
        if (!rd) begin
            check_eq("wdata_a", wd_a, golden[{sa, 8'h00} + 16'(b)]);
            check_eq("wdata_b", wd_b, golden[{sb, 8'h00} + 16'(b)]);
        end
    endtask

    // Runs one transfer of page p; optional restart to p2 at cycle rs_k, optional reset at rst_k.
    task automatic run_xfer(input logic [7:0] p, input int rs_k, input logic [7:0] p2,
                            input int rst_k);
        logic [7:0] sa, sb;
        int k, ea, eb;
        bit restarted;
        restarted = 0;
        dma_reg = p; dma_write = 1'b1; clr_oam = 1'b1;
        sa = fold(p); sb = p;
        @(negedge clk);
        dma_write = 1'b0; clr_oam = 1'b0;
        k = 1;
        while (k <= 4 * N) begin
            check_cycle(k, sa, sb);
            if (rst_k == k) begin
                rst = 1'b0;
                #1 check_zero();
                @(negedge clk);
                rst = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    check_idle("post_rst", 1'b0);
                end
                return;
            end
            if (rs_k == k && !restarted) begin
                restarted = 1;
                dma_reg = p2; dma_write = 1'b1; clr_oam = 1'b1;
                sa = fold(p2); sb = p2;
                @(negedge clk);
                dma_write = 1'b0; clr_oam = 1'b0;
                k = 1;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        check_idle("done", 1'b1);
        @(negedge clk);
        check_idle("after", 1'b0);
        ea = 0; eb = 0;
        for (int i = 0; i < N; i++) begin
            if (oam_a[i] !== golden[{sa, 8'h00} + 16'(i)]) ea++;
            if (oam_b[i] !== golden[{sb, 8'h00} + 16'(i)]) eb++;
        end
        check_eq("oam_a_errs", ea, 0);
        check_eq("oam_b_errs", eb, 0);
    endtask

    initial begin
        logic [7:0] p, p2;
        int rs;
        for (int a = 0; a < 65536; a++) golden[a] = 8'($urandom_range(1, 255));
        for (int i = 0; i < 256; i++) golden[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
        rst = 1'b0; dma_write = 1'b0; dma_reg = 8'h00; clr_oam = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_zero();
        rst = 1'b1;
        @(negedge clk);
        check_idle("idle", 1'b0);

        run_xfer(8'hC0, 0, 8'h00, 0);
        run_xfer(8'hE1, 0, 8'h00, 0);
        run_xfer(8'hC0, 50 * 4 + 4, 8'h80, 0);
        run_xfer(8'hC0, 0, 8'h00, 10 * 4 + 2);
        run_xfer(8'h30, 4 * N, 8'h45, 0);
        for (int t = 0; t < 4; t++) begin
            p  = 8'($urandom);
            p2 = 8'($urandom);
            rs = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4 * N)) : 0;
            run_xfer(p, rs, p2, 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
